// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - Z80 I/O port decode, command latch, read-ahead buffer, register file and status flags
module vdp_cpu_port (
    input  logic             clk,
    input  logic             rst_L,
    input  logic [7:0]       addr_bus,
    inout  wire  [7:0]       data_bus,
    input  logic             IORQ_L,
    input  logic             RD_L,
    input  logic             WR_L,
    output logic [13:0]      vram_addr,
    output logic [7:0]       vram_wdata,
    output logic             vram_we,
    output logic             vram_re,
    input  logic [7:0]       vram_rdata,
    output logic [4:0]       cram_addr,
    output logic [7:0]       cram_wdata,
    output logic             cram_we,
    output logic [10:0][7:0] vdp_regs,
    input  logic             vblank_set,
    input  logic             ovf_set,
    input  logic             coll_set,
    output logic             int_L
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PF_REQ,
        S_PF_LOAD,
        S_WR_VRAM,
        S_WR_CRAM
    } acc_state_t;

    acc_state_t  state, state_nxt;
    logic [13:0] addr;
    logic [1:0]  code;
    logic        second;
    logic [7:0]  rbuf;
    logic [2:0]  status;
    logic        wr_n, rd_n, wr_n_q, rd_n_q;
    logic        rd_busy, rd_ctrl;
    logic        sel, wr_ev, rd_ev, rd_rel, st_clr, pf_start, dwr_start, rd_drive;
    logic        unused_addr_bits;

    assign sel       = (addr_bus[7:6] == 2'b10);
    assign wr_n      = IORQ_L | WR_L;
    assign rd_n      = IORQ_L | RD_L;
    assign wr_ev     = sel & wr_n_q & ~wr_n;
    assign rd_ev     = sel & rd_n_q & ~rd_n;
    // Release acts on the port latched at the start of the read, not the live address.
    assign rd_rel    = rd_busy & rd_n;
    assign st_clr    = rd_rel & rd_ctrl;
    assign pf_start  = (wr_ev & addr_bus[0] & second & (data_bus[7:6] == 2'b00))
                     | (rd_rel & ~rd_ctrl);
    assign dwr_start = wr_ev & ~addr_bus[0];

    assign rd_drive  = sel & ~IORQ_L & ~RD_L;
    assign data_bus  = rd_drive ? (addr_bus[0] ? {status, 5'b0} : rbuf) : 8'bz;

    assign vram_addr  = addr;
    assign cram_addr  = addr[4:0];
    assign vram_wdata = rbuf;
    assign cram_wdata = rbuf;
    assign int_L      = ~(status[2] & vdp_regs[1][5]);

    assign unused_addr_bits = ^addr_bus[5:1];

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        vram_we   = 1'b0;
        vram_re   = 1'b0;
        cram_we   = 1'b0;
        case (state)
            S_PF_REQ: begin
                vram_re   = 1'b1;
                state_nxt = S_PF_LOAD;
            end
            S_WR_VRAM: vram_we = 1'b1;
            S_WR_CRAM: cram_we = 1'b1;
            default: ;
        endcase
        if (dwr_start) begin
            state_nxt = (code == 2'd3) ? S_WR_CRAM : S_WR_VRAM;
        end else if (pf_start) begin
            state_nxt = S_PF_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            addr     <= '0;
            code     <= '0;
            second   <= 1'b0;
            rbuf     <= '0;
            status   <= '0;
            vdp_regs <= '0;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            rd_busy  <= 1'b0;
            rd_ctrl  <= 1'b0;
        end else begin
            wr_n_q <= wr_n;
            rd_n_q <= rd_n;
            // A set pulse coinciding with the read-release clear keeps the flag.
            status <= (status & ~{3{st_clr}}) | {vblank_set, ovf_set, coll_set};

            if (state == S_PF_LOAD) begin
                rbuf <= vram_rdata;
            end
            if (state == S_PF_LOAD || state == S_WR_VRAM || state == S_WR_CRAM) begin
                addr <= addr + 14'd1;
            end

            if (rd_ev) begin
                rd_busy <= 1'b1;
                rd_ctrl <= addr_bus[0];
                if (!addr_bus[0]) begin
                    second <= 1'b0;
                end
            end else if (rd_n) begin
                rd_busy <= 1'b0;
            end
            if (st_clr) begin
                second <= 1'b0;
            end

            if (wr_ev) begin
                if (addr_bus[0]) begin
                    if (!second) begin
                        addr[7:0] <= data_bus;
                        second    <= 1'b1;
                    end else begin
                        addr[13:8] <= data_bus[5:0];
                        code       <= data_bus[7:6];
                        second     <= 1'b0;
                        if (data_bus[7:6] == 2'b10 && data_bus[3:0] < 4'd11) begin
                            vdp_regs[data_bus[3:0]] <= addr[7:0];
                        end
                    end
                end else begin
                    second <= 1'b0;
                    rbuf   <= data_bus;
                end
            end
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb/tb_vdp_cpu_port.sv - self-checking bench for vdp_cpu_port against a port-level behavioural model
module tb_vdp_cpu_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_L;
    logic [7:0]       addr_bus;
    wire  [7:0]       data_bus;
    logic             IORQ_L, RD_L, WR_L;
    logic [13:0]      vram_addr;
    logic [7:0]       vram_wdata, vram_rdata, cram_wdata;
    logic             vram_we, vram_re, cram_we;
    logic [4:0]       cram_addr;
    logic [10:0][7:0] vdp_regs;
    logic             vblank_set, ovf_set, coll_set, int_L;

    logic       tb_drv;
    logic [7:0] tb_d;
    assign data_bus = tb_drv ? tb_d : 8'bz;

    int total = 0;
    int bad   = 0;

    vdp_cpu_port dut (
        .clk(clk), .rst_L(rst_L), .addr_bus(addr_bus), .data_bus(data_bus),
        .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .vram_re(vram_re), .vram_rdata(vram_rdata),
        .cram_addr(cram_addr), .cram_wdata(cram_wdata), .cram_we(cram_we),
        .vdp_regs(vdp_regs), .vblank_set(vblank_set), .ovf_set(ovf_set),
        .coll_set(coll_set), .int_L(int_L)
    );

    // VRAM memory behind the port, and logs of every strobe cycle seen
    logic [7:0]  mem [0:16383];
    logic [21:0] vwr_log [$];
    logic [12:0] cwr_log [$];
    int          re_cnt = 0;

    always @(posedge clk) if (vram_re) vram_rdata <= mem[vram_addr];

    always @(negedge clk) begin
        if (vram_we) begin
            mem[vram_addr] = vram_wdata;
            vwr_log.push_back({vram_addr, vram_wdata});
        end
        if (cram_we) cwr_log.push_back({cram_addr, cram_wdata});
        if (vram_re) re_cnt++;
    end

    // Behavioural model of the port
    logic [13:0] m_addr;
    logic [1:0]  m_code;
    bit          m_second;
    logic [7:0]  m_rbuf;
    logic [2:0]  m_status;
    logic [7:0]  m_regs [0:10];
    logic [7:0]  m_vram [0:16383];
    logic [21:0] m_vwr [$];
    logic [12:0] m_cwr [$];
    int          m_re = 0;

    task automatic m_reset;
        m_addr = '0; m_code = '0; m_second = 0; m_rbuf = '0; m_status = '0;
        for (int i = 0; i < 11; i++) m_regs[i] = '0;
    endtask

    task automatic m_prefetch;
        m_rbuf = m_vram[m_addr];
        m_addr = m_addr + 1;
        m_re++;
    endtask

    task automatic m_ctrl_wr(input logic [7:0] d);
        if (!m_second) begin
            m_addr[7:0] = d;
            m_second = 1;
        end else begin
            m_addr[13:8] = d[5:0];
            m_code = d[7:6];
            m_second = 0;
            if (m_code == 2'd0) m_prefetch();
            if (m_code == 2'd2 && d[3:0] < 11) m_regs[d[3:0]] = m_addr[7:0];
        end
    endtask

    task automatic m_data_wr(input logic [7:0] d);
        m_second = 0;
        m_rbuf = d;
        if (m_code == 2'd3) begin
            m_cwr.push_back({m_addr[4:0], d});
        end else begin
            m_vwr.push_back({m_addr, d});
            m_vram[m_addr] = d;
        end
        m_addr = m_addr + 1;
    endtask

    // CPU bus cycles: strobes held two clocks, then idle four
    task automatic op_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr_bus = a; tb_d = d; tb_drv = 1; IORQ_L = 0; WR_L = 0;
        repeat (2) @(negedge clk);
        IORQ_L = 1; WR_L = 1; tb_drv = 0;
        repeat (4) @(negedge clk);
        if (a[7:6] == 2'b10) begin
            if (a[0]) m_ctrl_wr(d);
            else m_data_wr(d);
        end
    endtask

    task automatic op_read(input logic [7:0] a, input bit vb_rel,
                           output logic [7:0] got, output logic [7:0] exp);
        @(negedge clk);
        addr_bus = a; IORQ_L = 0; RD_L = 0;
        repeat (2) @(negedge clk);
        got = data_bus;
        IORQ_L = 1; RD_L = 1; vblank_set = vb_rel;
        @(negedge clk);
        vblank_set = 0;
        repeat (3) @(negedge clk);
        exp = 8'h00;
        if (a[7:6] == 2'b10) begin
            if (a[0]) begin
                exp = {m_status, 5'b0};
                m_status = '0;
                m_second = 0;
            end else begin
                exp = m_rbuf;
                m_second = 0;
                m_prefetch();
            end
        end
        if (vb_rel) m_status[2] = 1'b1;
    endtask

    task automatic pulse_status(input logic [2:0] s);
        @(negedge clk);
        {vblank_set, ovf_set, coll_set} = s;
        @(negedge clk);
        {vblank_set, ovf_set, coll_set} = 3'b000;
        m_status = m_status | s;
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_logs;
        vwr_log.delete(); cwr_log.delete(); m_vwr.delete(); m_cwr.delete();
    endtask

    task automatic test_reset;
        logic [7:0] g, e;
        rst_L = 0; addr_bus = 8'h00; IORQ_L = 1; RD_L = 1; WR_L = 1;
        tb_drv = 0; tb_d = 8'h00; vblank_set = 0; ovf_set = 0; coll_set = 0;
        repeat (3) @(negedge clk);
        rst_L = 1;
        m_reset();
        repeat (2) @(negedge clk);
        total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL reset_vram_we got=%b exp=0", vram_we); end
        total++; if (vram_re !== 1'b0) begin bad++; $display("FAIL reset_vram_re got=%b exp=0", vram_re); end
        total++; if (cram_we !== 1'b0) begin bad++; $display("FAIL reset_cram_we got=%b exp=0", cram_we); end
        total++; if (int_L !== 1'b1) begin bad++; $display("FAIL reset_int_L got=%b exp=1", int_L); end
        total++; if (vdp_regs !== 88'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", vdp_regs); end
        op_read(8'hBF, 0, g, e);
        total++; if (g !== 8'h00) begin bad++; $display("FAIL reset_ctrl_read got=%h exp=00", g); end
    endtask

    task automatic test_vram_write;
        clear_logs();
        op_write(8'hBF, 8'h00); op_write(8'hBF, 8'h40);
        op_write(8'hBE, 8'hAA); op_write(8'hBE, 8'h55); op_write(8'hBE, 8'h77);
        total++; if (vwr_log.size() != 3) begin bad++; $display("FAIL vwr_count got=%0d exp=3", vwr_log.size()); end
        total++; if (vwr_log[0] !== {14'h0000, 8'hAA}) begin bad++; $display("FAIL vwr0 got=%h exp=%h", vwr_log[0], {14'h0000, 8'hAA}); end
        total++; if (vwr_log[1] !== {14'h0001, 8'h55}) begin bad++; $display("FAIL vwr1 got=%h exp=%h", vwr_log[1], {14'h0001, 8'h55}); end
        total++; if (vwr_log[2] !== {14'h0002, 8'h77}) begin bad++; $display("FAIL vwr_final_addr got=%h exp=%h", vwr_log[2], {14'h0002, 8'h77}); end
    endtask

    task automatic test_cram_wrap;
        clear_logs();
        op_write(8'hBF, 8'h1F); op_write(8'hBF, 8'hC0);
        op_write(8'hBE, 8'h3F); op_write(8'hBE, 8'h01);
        total++; if (cwr_log.size() != 2 || vwr_log.size() != 0) begin bad++; $display("FAIL cram_count got=%0d/%0d exp=2/0", cwr_log.size(), vwr_log.size()); end
        total++; if (cwr_log[0] !== {5'h1F, 8'h3F}) begin bad++; $display("FAIL cram0 got=%h exp=%h", cwr_log[0], {5'h1F, 8'h3F}); end
        total++; if (cwr_log[1] !== {5'h00, 8'h01}) begin bad++; $display("FAIL cram1 got=%h exp=%h", cwr_log[1], {5'h00, 8'h01}); end
        clear_logs();
        op_write(8'hBF, 8'hFF); op_write(8'hBF, 8'h7F);
        op_write(8'hBE, 8'hA5); op_write(8'hBE, 8'h5A);
        total++; if (vwr_log[0] !== {14'h3FFF, 8'hA5}) begin bad++; $display("FAIL wrap0 got=%h exp=%h", vwr_log[0], {14'h3FFF, 8'hA5}); end
        total++; if (vwr_log[1] !== {14'h0000, 8'h5A}) begin bad++; $display("FAIL wrap1 got=%h exp=%h", vwr_log[1], {14'h0000, 8'h5A}); end
    endtask

    task automatic test_reg_int;
        logic [7:0] g, e;
        op_write(8'hBF, 8'h20); op_write(8'hBF, 8'h81);
        total++; if (vdp_regs[1] !== 8'h20) begin bad++; $display("FAIL reg1 got=%h exp=20", vdp_regs[1]); end
        total++; if (int_L !== 1'b1) begin bad++; $display("FAIL int_idle got=%b exp=1", int_L); end
        pulse_status(3'b100);
        total++; if (int_L !== 1'b0) begin bad++; $display("FAIL int_vblank got=%b exp=0", int_L); end
        op_read(8'hBF, 0, g, e);
        total++; if (g !== 8'h80) begin bad++; $display("FAIL status_read got=%h exp=80", g); end
        total++; if (int_L !== 1'b1) begin bad++; $display("FAIL int_cleared got=%b exp=1", int_L); end
    endtask

    task automatic test_read_buffer;
        logic [7:0] g1, g2, e;
        int re0;
        mem[14'h0100] = 8'h11; m_vram[14'h0100] = 8'h11;
        mem[14'h0101] = 8'h22; m_vram[14'h0101] = 8'h22;
        clear_logs();
        re0 = re_cnt;
        op_write(8'hBF, 8'h00); op_write(8'hBF, 8'h01);
        op_read(8'hBE, 0, g1, e);
        op_read(8'hBE, 0, g2, e);
        op_write(8'hBE, 8'hC3);
        total++; if (g1 !== 8'h11) begin bad++; $display("FAIL rbuf_first got=%h exp=11", g1); end
        total++; if (g2 !== 8'h22) begin bad++; $display("FAIL rbuf_second got=%h exp=22", g2); end
        total++; if (vwr_log[0] !== {14'h0103, 8'hC3}) begin bad++; $display("FAIL rbuf_addr got=%h exp=%h", vwr_log[0], {14'h0103, 8'hC3}); end
        total++; if (re_cnt - re0 != 3) begin bad++; $display("FAIL prefetch_count got=%0d exp=3", re_cnt - re0); end
    endtask

    task automatic test_flag_reset;
        logic [7:0] g, e;
        clear_logs();
        op_write(8'hBF, 8'h12);
        op_read(8'hBE, 0, g, e);
        op_write(8'hBF, 8'h34); op_write(8'hBF, 8'h40);
        op_write(8'hBE, 8'h9C);
        total++; if (vwr_log[0] !== {14'h0034, 8'h9C}) begin bad++; $display("FAIL second_clear got=%h exp=%h", vwr_log[0], {14'h0034, 8'h9C}); end
    endtask

    task automatic test_simul_status;
        logic [7:0] g, e;
        op_read(8'hBF, 1, g, e);
        total++; if (g !== 8'h00) begin bad++; $display("FAIL simul_first got=%h exp=00", g); end
        total++; if (int_L !== 1'b0) begin bad++; $display("FAIL simul_int got=%b exp=0", int_L); end
        op_read(8'hBF, 0, g, e);
        total++; if (g !== 8'h80) begin bad++; $display("FAIL simul_set_wins got=%h exp=80", g); end
        op_read(8'hBF, 0, g, e);
        total++; if (g !== 8'h00) begin bad++; $display("FAIL simul_cleared got=%h exp=00", g); end
    endtask

    task automatic test_unselected;
        logic [7:0] g, e;
        int re0;
        clear_logs();
        re0 = re_cnt;
        op_write(8'h7E, 8'h11); op_write(8'h7F, 8'h82); op_write(8'h3F, 8'h00);
        op_write(8'hFE, 8'h66); op_write(8'hC1, 8'h81);
        op_read(8'h7E, 0, g, e); op_read(8'hFF, 0, g, e);
        total++; if (vwr_log.size() + cwr_log.size() != 0 || re_cnt != re0) begin bad++; $display("FAIL unsel_strobes got=%0d/%0d exp=0/0", vwr_log.size() + cwr_log.size(), re_cnt - re0); end
        total++; if (vdp_regs[1] !== m_regs[1] || vdp_regs[2] !== m_regs[2]) begin bad++; $display("FAIL unsel_regs got=%h exp=%h", vdp_regs[1], m_regs[1]); end
        op_write(8'hBE, 8'h4D);
        total++; if (vwr_log[0] !== m_vwr[0]) begin bad++; $display("FAIL unsel_addr got=%h exp=%h", vwr_log[0], m_vwr[0]); end
    endtask

    task automatic test_reset_mid_prefetch;
        logic [7:0] g, e;
        int re0;
        op_read(8'hBF, 0, g, e);
        op_write(8'hBF, 8'h00);
        pulse_status(3'b100);
        clear_logs();
        re0 = re_cnt;
        @(negedge clk);
        addr_bus = 8'hBF; tb_d = 8'h00; tb_drv = 1; IORQ_L = 0; WR_L = 0;
        @(posedge clk);
        #1 rst_L = 0;
        @(negedge clk);
        IORQ_L = 1; WR_L = 1; tb_drv = 0;
        repeat (3) @(negedge clk);
        rst_L = 1;
        m_reset();
        repeat (5) @(negedge clk);
        total++; if (re_cnt != re0 || vwr_log.size() != 0) begin bad++; $display("FAIL rst_mid_strobe got=%0d exp=0", re_cnt - re0); end
        total++; if (vdp_regs !== 88'h0) begin bad++; $display("FAIL rst_mid_regs got=%h exp=0", vdp_regs); end
        total++; if (int_L !== 1'b1) begin bad++; $display("FAIL rst_mid_int got=%b exp=1", int_L); end
        op_read(8'hBF, 0, g, e);
        total++; if (g !== 8'h00) begin bad++; $display("FAIL rst_mid_status got=%h exp=00", g); end
    endtask

    task automatic test_random;
        logic [7:0] g, e, a, d;
        int re0, k;
        clear_logs();
        re0 = re_cnt;
        m_re = 0;
        for (int i = 0; i < 160; i++) begin
            k = $urandom_range(0, 6);
            d = 8'($urandom);
            a = {2'b10, 5'($urandom), 1'b0};
            case (k)
                0, 1: op_write(a | 8'h01, d);
                2:    op_write(a, d);
                3: begin
                    op_read(a, 0, g, e);
                    total++; if (g !== e) begin bad++; $display("FAIL rnd_data_read i=%0d got=%h exp=%h", i, g, e); end
                end
                4: begin
                    op_read(a | 8'h01, 0, g, e);
                    total++; if (g !== e) begin bad++; $display("FAIL rnd_ctrl_read i=%0d got=%h exp=%h", i, g, e); end
                end
                5: pulse_status(3'($urandom));
                default: begin
                    a = 8'($urandom);
                    if (a[7:6] == 2'b10) a[7] = 1'b0;
                    op_write(a, d);
                end
            endcase
            total++; if (int_L !== ~(m_status[2] & m_regs[1][5])) begin bad++; $display("FAIL rnd_int i=%0d got=%b exp=%b", i, int_L, ~(m_status[2] & m_regs[1][5])); end
        end
        total++; if (re_cnt - re0 != m_re) begin bad++; $display("FAIL rnd_prefetch_count got=%0d exp=%0d", re_cnt - re0, m_re); end
        total++; if (vwr_log.size() != m_vwr.size() || cwr_log.size() != m_cwr.size()) begin bad++; $display("FAIL rnd_write_count got=%0d/%0d exp=%0d/%0d", vwr_log.size(), cwr_log.size(), m_vwr.size(), m_cwr.size()); end
        for (int i = 0; i < m_vwr.size(); i++) begin
            total++; if (vwr_log[i] !== m_vwr[i]) begin bad++; $display("FAIL rnd_vwr%0d got=%h exp=%h", i, vwr_log[i], m_vwr[i]); end
        end
        for (int i = 0; i < m_cwr.size(); i++) begin
            total++; if (cwr_log[i] !== m_cwr[i]) begin bad++; $display("FAIL rnd_cwr%0d got=%h exp=%h", i, cwr_log[i], m_cwr[i]); end
        end
        for (int i = 0; i < 11; i++) begin
            total++; if (vdp_regs[i] !== m_regs[i]) begin bad++; $display("FAIL rnd_reg%0d got=%h exp=%h", i, vdp_regs[i], m_regs[i]); end
        end
    endtask

    initial begin
        vram_rdata = 8'h00;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 8'($urandom);
            m_vram[i] = mem[i];
        end
        test_reset();
        test_vram_write();
        test_cram_wrap();
        test_reg_int();
        test_read_buffer();
        test_flag_reset();
        test_simul_status();
        test_unselected();
        test_reset_mid_prefetch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
